// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared types and constants for the serial pattern generator and its
// embedded overlapping-10110 tracker.
//   op_e         command opcodes carried on cmd_op
//   ser_state_e  command/shift FSM states of the serializer
//   det_state_e  states of the 10110 tracker (mirrors the sequence detector)
//   BASE_PATTERN / OVERLAP_PATTERN and their bit lengths
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    OP_RAW     = 2'd0,
    OP_BASE    = 2'd1,
    OP_OVERLAP = 2'd2,
    OP_GAP     = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } ser_state_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_1,
    ST_10,
    ST_101,
    ST_1011,
    ST_10110
  } det_state_e;

  localparam int                   BASE_LEN        = 5;
  localparam logic [BASE_LEN-1:0]  BASE_PATTERN    = 5'b10110;
  localparam int                   OVERLAP_LEN     = 3;
  localparam logic [OVERLAP_LEN-1:0] OVERLAP_PATTERN = 3'b110;

endpackage

// File: rtl/seq_pattern_serializer_if.sv
// ---------------------------------------------------------------------------
// seq_pattern_serializer_if
// Bundles the command channel, the serial output channel and the match
// reporting of the serializer.
//   cmd_valid/cmd_ready  command handshake (accept on cmd_valid && cmd_ready)
//   cmd_op/data/len      command opcode, RAW payload, RAW bits / GAP cycles
//   seq/valid/ready      serial bit stream, transfer on valid && ready
//   match/match_count    one-cycle match pulse and wrapping match counter
// Modports:
//   master  drives commands and downstream ready (stimulus / upstream side)
//   slave   the serializer itself
// ---------------------------------------------------------------------------
interface seq_pattern_serializer_if #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 16
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [MAX_LEN-1:0] cmd_data;
  logic [LEN_W-1:0]   cmd_len;
  logic               seq;
  logic               valid;
  logic               ready;
  logic               match;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_len, ready,
    input  cmd_ready, seq, valid, match, match_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_len, ready,
    output cmd_ready, seq, valid, match, match_count
  );

endinterface

// File: rtl/seq_pattern_tracker.sv
// ---------------------------------------------------------------------------
// seq_pattern_tracker
// Overlapping 10110 detector. Advances only on bits qualified by bit_valid,
// so stalls and gaps in the stream leave its state untouched.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (state -> ST_IDLE, match -> 0)
//   bit_in     serial bit being transferred
//   bit_valid  bit_in is a real transfer this cycle
//   match      registered one-cycle pulse the cycle after the completing 0
// ---------------------------------------------------------------------------
module seq_pattern_tracker
  import seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic bit_valid,
  output logic match
);

  det_state_e state_q, state_d;
  logic       match_q, match_d;

  // Next-state decode. After a completed 10110 the trailing "10" is kept as
  // a prefix (ST_10110 behaves like ST_10 on the next bit), which is what
  // makes back-to-back overlapping patterns such as 10110110 match twice.
  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    if (bit_valid) begin
      case (state_q)
        ST_IDLE:  state_d = bit_in ? ST_1    : ST_IDLE;
        ST_1:     state_d = bit_in ? ST_1    : ST_10;
        ST_10:    state_d = bit_in ? ST_101  : ST_IDLE;
        ST_101:   state_d = bit_in ? ST_1011 : ST_10;
        ST_1011: begin
          if (bit_in) begin
            state_d = ST_1;
          end else begin
            state_d = ST_10110;
            match_d = 1'b1;
          end
        end
        ST_10110: state_d = bit_in ? ST_101  : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State and match pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

endmodule

// File: rtl/seq_pattern_serializer.sv
// ---------------------------------------------------------------------------
// seq_pattern_serializer
// Bit-serial stream generator. Takes RAW / BASE / OVERLAP / GAP commands over
// a valid/ready channel and shifts bits out MSB-first under downstream
// back-pressure, while an embedded tracker flags each emitted 10110.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; discards any in-flight command
//   bus    seq_pattern_serializer_if.slave
//          cmd_valid/cmd_ready/cmd_op/cmd_data/cmd_len  command channel
//          seq/valid/ready                              serial output
//          match/match_count                            match reporting
// ---------------------------------------------------------------------------
module seq_pattern_serializer
  import seq_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  seq_pattern_serializer_if.slave   bus
);

  ser_state_e         state_q, state_d;
  logic [MAX_LEN-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   match_count_q, match_count_d;

  op_e              cmd_op;
  logic [LEN_W-1:0] eff_len;
  logic             xfer;
  logic             last_bit;
  logic             cmd_ready;
  logic             cmd_accept;
  logic             tracker_match;

  assign cmd_op  = op_e'(bus.cmd_op);
  assign eff_len = (bus.cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cmd_len;

  // Handshake decode. cmd_ready opens during the final transfer of a shift
  // so the next command's first bit follows with no bubble. It never looks
  // at cmd_valid, and it stays low while reset is asserted.
  always_comb begin
    xfer       = valid_q && bus.ready;
    last_bit   = (state_q == S_SHIFT) && xfer && (rem_q == LEN_W'(1));
    cmd_ready  = !reset && ((state_q == S_IDLE) || last_bit);
    cmd_accept = bus.cmd_valid && cmd_ready;
  end

  // Command FSM, shift register and length/gap counter. The shift register
  // holds the remaining bits left-aligned so seq is always its MSB; unused
  // low bits are zero, so it drains to zero and seq idles low.
  // A GAP of n produces n cycles of valid=0 in a back-to-back stream: n-1 of
  // them are spent in S_GAP and the last is the S_IDLE cycle in which the
  // following command is accepted.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    rem_d   = rem_q;
    valid_d = valid_q;

    case (state_q)
      S_SHIFT: begin
        if (bus.ready) begin
          shift_d = shift_q << 1;
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end
        end
      end
      S_GAP: begin
        rem_d = rem_q - LEN_W'(1);
        if (rem_q <= LEN_W'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
      end
    endcase

    if (cmd_accept) begin
      case (cmd_op)
        OP_BASE: begin
          shift_d = MAX_LEN'(BASE_PATTERN) << (MAX_LEN - BASE_LEN);
          rem_d   = LEN_W'(BASE_LEN);
          state_d = S_SHIFT;
          valid_d = 1'b1;
        end
        OP_OVERLAP: begin
          shift_d = MAX_LEN'(OVERLAP_PATTERN) << (MAX_LEN - OVERLAP_LEN);
          rem_d   = LEN_W'(OVERLAP_LEN);
          state_d = S_SHIFT;
          valid_d = 1'b1;
        end
        OP_RAW: begin
          if (eff_len != '0) begin
            shift_d = bus.cmd_data << (LEN_W'(MAX_LEN) - eff_len);
            rem_d   = eff_len;
            state_d = S_SHIFT;
            valid_d = 1'b1;
          end else begin
            shift_d = '0;
            rem_d   = '0;
            state_d = S_IDLE;
            valid_d = 1'b0;
          end
        end
        OP_GAP: begin
          shift_d = '0;
          valid_d = 1'b0;
          if (eff_len > LEN_W'(1)) begin
            rem_d   = eff_len - LEN_W'(1);
            state_d = S_GAP;
          end else begin
            rem_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Match counter wraps naturally at 2^CNT_W.
  always_comb begin
    match_count_d = match_count_q + CNT_W'(tracker_match);
  end

  // All serializer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      rem_q         <= '0;
      valid_q       <= 1'b0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      rem_q         <= rem_d;
      valid_q       <= valid_d;
      match_count_q <= match_count_d;
    end
  end

  seq_pattern_tracker u_tracker (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (shift_q[MAX_LEN-1]),
    .bit_valid (xfer),
    .match     (tracker_match)
  );

  assign bus.cmd_ready   = cmd_ready;
  assign bus.seq         = shift_q[MAX_LEN-1];
  assign bus.valid       = valid_q;
  assign bus.match       = tracker_match;
  assign bus.match_count = match_count_q;

endmodule

// File: tb/tb_seq_pattern_serializer.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_serializer
// Directed bench for seq_pattern_serializer: a per-cycle vector table for
// single-command behaviour and hand-written sequences for back-pressure,
// gaps, mid-stream reset and length clamping.
// ---------------------------------------------------------------------------
module tb_seq_pattern_serializer;
  import seq_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 16;
  localparam int LEN_W   = 5;

  logic clk;
  logic reset;

  seq_pattern_serializer_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_pattern_serializer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // One row per clock cycle: inputs applied before the edge, outputs
  // expected in that same cycle.
  typedef struct {
    logic        rst;
    logic        cv;
    logic [1:0]  op;
    logic [15:0] data;
    logic [4:0]  len;
    logic        rdy;
    logic        e_cready;
    logic        e_valid;
    logic        e_seq;
    logic        e_match;
    logic [15:0] e_count;
  } vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [4:0]  len;
  } cmd_t;

  vec_t vecs[$];
  cmd_t cmd_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [63:0] cap_bits;
  int          cap_count;
  int          match_pulses;
  int          stall_errs;
  int          stall_seen;
  int          gap_low;
  int          gap_low_busy;
  int          first_x;
  int          last_x;
  bit          valid_hist[$];
  bit          cr_hist[$];

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence never finishes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t row(logic rst, logic cv, logic [1:0] op, logic [15:0] data,
                               logic [4:0] len, logic rdy, logic e_cready, logic e_valid,
                               logic e_seq, logic e_match, logic [15:0] e_count);
    vec_t v;
    v.rst = rst; v.cv = cv; v.op = op; v.data = data; v.len = len; v.rdy = rdy;
    v.e_cready = e_cready; v.e_valid = e_valid; v.e_seq = e_seq;
    v.e_match = e_match; v.e_count = e_count;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset         = v.rst;
    bus.cmd_valid = v.cv;
    bus.cmd_op    = v.op;
    bus.cmd_data  = v.data;
    bus.cmd_len   = v.len;
    bus.ready     = v.rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; bus.cmd_valid = 1'b0; bus.ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs a fixed number of cycles, feeding cmd_q in order and recording the
  // transferred bits, match pulses, stall stability and the shape of any
  // valid-low stretch between the first and last transfer.
  task automatic runSequence(input int cycles, input bit toggle_ready);
    logic prev_valid, prev_ready, prev_seq;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_seq = 1'b0;
    cap_bits = '0; cap_count = 0; match_pulses = 0; stall_errs = 0; stall_seen = 0;
    gap_low = 0; gap_low_busy = 0; first_x = -1; last_x = -1;
    valid_hist.delete(); cr_hist.delete();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (cmd_q.size() > 0) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = cmd_q[0].op;
        bus.cmd_data  = cmd_q[0].data;
        bus.cmd_len   = cmd_q[0].len;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      bus.ready = toggle_ready ? (c % 2 == 1) : 1'b1;
      #1;
      if (prev_valid && !prev_ready) begin
        stall_seen++;
        if (!bus.valid || bus.seq !== prev_seq) stall_errs++;
      end
      if (bus.valid && bus.ready) begin
        cap_bits = {cap_bits[62:0], bus.seq};
        if (first_x < 0) first_x = c;
        last_x = c;
        cap_count++;
      end
      if (bus.match) match_pulses++;
      valid_hist.push_back(bus.valid);
      cr_hist.push_back(bus.cmd_ready);
      if (bus.cmd_valid && bus.cmd_ready) void'(cmd_q.pop_front());
      prev_valid = bus.valid; prev_ready = bus.ready; prev_seq = bus.seq;
    end
    bus.cmd_valid = 1'b0;
    bus.ready     = 1'b1;
    if (first_x >= 0) begin
      for (int i = first_x + 1; i < last_x; i++) begin
        if (!valid_hist[i]) gap_low++;
        if (!valid_hist[i] && !cr_hist[i]) gap_low_busy++;
      end
    end
  endtask

  initial begin
    int  xfers;
    bit  reset_done;

    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_data = '0; bus.cmd_len = '0;
    bus.ready = 1'b1;

    // BASE with ready=1: 1,0,1,1,0 then one match, count 1.
    vecs.push_back(row(0, 1, OP_BASE, 16'h0, 5'd0, 1,  1, 0, 0, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,  16'h0, 5'd0, 1,  0, 1, 1, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,  16'h0, 5'd0, 1,  0, 1, 0, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,  16'h0, 5'd0, 1,  0, 1, 1, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,  16'h0, 5'd0, 1,  0, 1, 1, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,  16'h0, 5'd0, 1,  1, 1, 0, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,  16'h0, 5'd0, 1,  1, 0, 0, 1, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,  16'h0, 5'd0, 1,  1, 0, 0, 0, 16'd1));
    // Reset, then BASE with OVERLAP queued on the last bit: 10110110.
    vecs.push_back(row(1, 0, OP_RAW,     16'h0, 5'd0, 1,  0, 0, 0, 0, 16'd1));
    vecs.push_back(row(0, 1, OP_BASE,    16'h0, 5'd0, 1,  1, 0, 0, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 1,  0, 1, 1, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 1,  0, 1, 0, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 1,  0, 1, 1, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 1,  0, 1, 1, 0, 16'd0));
    vecs.push_back(row(0, 1, OP_OVERLAP, 16'h0, 5'd0, 1,  1, 1, 0, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 1,  0, 1, 1, 1, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 1,  0, 1, 1, 0, 16'd1));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 1,  1, 1, 0, 0, 16'd1));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 1,  1, 0, 0, 1, 16'd1));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 1,  1, 0, 0, 0, 16'd2));
    // Reset, RAW len 0: nothing emitted, cmd_ready stays high.
    vecs.push_back(row(1, 0, OP_RAW, 16'h0,    5'd0, 1,  0, 0, 0, 0, 16'd2));
    vecs.push_back(row(0, 1, OP_RAW, 16'hFFFF, 5'd0, 1,  1, 0, 0, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW, 16'h0,    5'd0, 1,  1, 0, 0, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW, 16'h0,    5'd0, 1,  1, 0, 0, 0, 16'd0));
    // OVERLAP with stalls on the first and last bit; 110 alone never matches.
    vecs.push_back(row(0, 1, OP_OVERLAP, 16'h0, 5'd0, 1,  1, 0, 0, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 0,  0, 1, 1, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 1,  0, 1, 1, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 1,  0, 1, 1, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 0,  0, 1, 0, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 1,  1, 1, 0, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 1,  1, 0, 0, 0, 16'd0));
    vecs.push_back(row(0, 0, OP_RAW,     16'h0, 5'd0, 1,  1, 0, 0, 0, 16'd0));

    // Reset state, checked while reset is still held.
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("reset valid", 32'(bus.valid), 32'd0);
    checkOutput("reset seq", 32'(bus.seq), 32'd0);
    checkOutput("reset match", 32'(bus.match), 32'd0);
    checkOutput("reset match_count", 32'(bus.match_count), 32'd0);
    reset = 1'b0;

    // Vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("row%0d cmd_ready", i), 32'(bus.cmd_ready), 32'(vecs[i].e_cready));
      checkOutput($sformatf("row%0d valid", i), 32'(bus.valid), 32'(vecs[i].e_valid));
      checkOutput($sformatf("row%0d seq", i), 32'(bus.seq), 32'(vecs[i].e_seq));
      checkOutput($sformatf("row%0d match", i), 32'(bus.match), 32'(vecs[i].e_match));
      checkOutput($sformatf("row%0d match_count", i), 32'(bus.match_count), 32'(vecs[i].e_count));
    end

    // RAW B5A3 with ready toggling: exact bits, stable while stalled.
    doReset();
    cmd_q.push_back('{op: OP_RAW, data: 16'hB5A3, len: 5'd16});
    runSequence(40, 1'b1);
    checkOutput("raw16 transfers", 32'(cap_count), 32'd16);
    checkOutput("raw16 bits", 32'(cap_bits[15:0]), 32'h0000B5A3);
    checkOutput("raw16 stall stability", 32'(stall_errs), 32'd0);
    checkOutput("raw16 stalls seen", 32'(stall_seen > 0), 32'd1);
    checkOutput("raw16 matches", 32'(match_pulses), 32'd2);

    // RAW 101, GAP 3, RAW 10: three valid-low cycles, two with cmd_ready low.
    doReset();
    cmd_q.push_back('{op: OP_RAW, data: 16'h0005, len: 5'd3});
    cmd_q.push_back('{op: OP_GAP, data: 16'h0000, len: 5'd3});
    cmd_q.push_back('{op: OP_RAW, data: 16'h0002, len: 5'd2});
    runSequence(14, 1'b0);
    checkOutput("gap transfers", 32'(cap_count), 32'd5);
    checkOutput("gap bits", 32'(cap_bits[4:0]), 32'h16);
    checkOutput("gap valid-low cycles", 32'(gap_low), 32'd3);
    checkOutput("gap cmd_ready-low cycles", 32'(gap_low_busy), 32'd2);
    checkOutput("gap matches", 32'(match_pulses), 32'd1);
    checkOutput("gap match_count", 32'(bus.match_count), 32'd1);

    // Reset while the 8th bit of RAW B5A3 is on the line.
    doReset();
    xfers = 0;
    reset_done = 1'b0;
    for (int c = 0; c < 30 && !reset_done; c++) begin
      @(negedge clk);
      bus.cmd_valid = (c == 0);
      bus.cmd_op    = OP_RAW;
      bus.cmd_data  = 16'hB5A3;
      bus.cmd_len   = 5'd16;
      bus.ready     = 1'b1;
      #1;
      if (bus.valid && xfers == 7) begin
        checkOutput("midreset 8th bit", 32'(bus.seq), 32'd1);
        checkOutput("midreset count before", 32'(bus.match_count), 32'd1);
        reset = 1'b1;
        reset_done = 1'b1;
      end else if (bus.valid) begin
        xfers++;
      end
    end
    checkOutput("midreset reached 8th bit", 32'(reset_done), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    checkOutput("midreset valid after", 32'(bus.valid), 32'd0);
    checkOutput("midreset count after", 32'(bus.match_count), 32'd0);
    checkOutput("midreset cmd_ready after", 32'(bus.cmd_ready), 32'd1);
    checkOutput("midreset match after", 32'(bus.match), 32'd0);
    cmd_q.push_back('{op: OP_BASE, data: 16'h0000, len: 5'd0});
    runSequence(10, 1'b0);
    checkOutput("midreset base transfers", 32'(cap_count), 32'd5);
    checkOutput("midreset base bits", 32'(cap_bits[4:0]), 32'h16);
    checkOutput("midreset base matches", 32'(match_pulses), 32'd1);
    checkOutput("midreset base count", 32'(bus.match_count), 32'd1);

    // RAW with len 20 is clamped to 16 bits.
    doReset();
    cmd_q.push_back('{op: OP_RAW, data: 16'hA5C3, len: 5'd20});
    runSequence(24, 1'b0);
    checkOutput("clamp transfers", 32'(cap_count), 32'd16);
    checkOutput("clamp bits", 32'(cap_bits[15:0]), 32'h0000A5C3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
